// File: rtl/weight_mem_arbiter.sv
// Shares the weight-memory port between the core sequencer (whole-row access)
// and the host loader (word stream packed into a row buffer before writing).
module weight_mem_arbiter #(
   parameter int unsigned ADDR_W = 8,
   parameter int unsigned LANES  = 16,
   parameter int unsigned DATA_W = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     core_req,
   input  logic                     core_we,
   input  logic [ADDR_W-1:0]        core_addr,
   input  logic [LANES*DATA_W-1:0]  core_wdata,
   output logic                     core_gnt,
   output logic                     core_rvalid,
   output logic [LANES*DATA_W-1:0]  core_rdata,
   input  logic                     host_valid,
   output logic                     host_ready,
   input  logic [ADDR_W-1:0]        host_addr,
   input  logic [DATA_W-1:0]        host_wdata,
   output logic                     mem_rd,
   output logic                     mem_wr,
   output logic [ADDR_W-1:0]        mem_addr,
   output logic [LANES*DATA_W-1:0]  mem_wdata,
   input  logic [LANES*DATA_W-1:0]  mem_rdata
);

   localparam int unsigned ROW_W  = LANES * DATA_W;
   localparam int unsigned LANE_W = $clog2(LANES);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CORE_RD = 2'd1,
      CORE_WR = 2'd2,
      HOST_WR = 2'd3
   } state_t;

   state_t                       state;
   state_t                       state_n;
   logic                         last_host;
   logic                         last_host_n;
   logic [LANE_W-1:0]            lane;
   logic [LANES-1:0][DATA_W-1:0] row_buf;
   logic [ADDR_W-1:0]            host_row_addr;

   logic                         full;
   logic                         host_accept;
   logic                         core_elig;
   logic                         host_elig;
   logic                         grant_core;
   logic                         grant_host;

   logic                         gnt_n;
   logic                         rvalid_n;
   logic                         rd_n;
   logic                         wr_n;
   logic [ADDR_W-1:0]            addr_n;
   logic [ROW_W-1:0]             wdata_n;

   assign full        = ~host_ready;
   assign host_accept = host_valid & host_ready;
   assign core_rdata  = mem_rdata;

   // A requester granted in the current cycle sits out the next decision.
   assign core_elig  = core_req && (state != CORE_RD) && (state != CORE_WR);
   assign host_elig  = full && (state != HOST_WR);
   assign grant_core = core_elig && (!host_elig || last_host);
   assign grant_host = host_elig && !grant_core;

   // Next-state and next registered outputs.
   always_comb begin
      state_n     = IDLE;
      last_host_n = last_host;
      gnt_n       = 1'b0;
      rvalid_n    = (state == CORE_RD);
      rd_n        = 1'b0;
      wr_n        = 1'b0;
      addr_n      = mem_addr;
      wdata_n     = mem_wdata;
      if (grant_core) begin
         state_n     = core_we ? CORE_WR : CORE_RD;
         last_host_n = 1'b0;
         gnt_n       = 1'b1;
         rd_n        = ~core_we;
         wr_n        = core_we;
         addr_n      = core_addr;
         if (core_we) begin
            wdata_n = core_wdata;
         end
      end else if (grant_host) begin
         state_n     = HOST_WR;
         last_host_n = 1'b1;
         wr_n        = 1'b1;
         addr_n      = host_row_addr;
         wdata_n     = row_buf;
      end
   end

   // State, round-robin pointer and registered memory/grant outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         last_host   <= 1'b1;
         core_gnt    <= 1'b0;
         core_rvalid <= 1'b0;
         mem_rd      <= 1'b0;
         mem_wr      <= 1'b0;
         mem_addr    <= '0;
         mem_wdata   <= '0;
      end else begin
         state       <= state_n;
         last_host   <= last_host_n;
         core_gnt    <= gnt_n;
         core_rvalid <= rvalid_n;
         mem_rd      <= rd_n;
         mem_wr      <= wr_n;
         mem_addr    <= addr_n;
         mem_wdata   <= wdata_n;
      end
   end

   // Host lane counter, row address latch and full flag (held as !host_ready).
   always_ff @(posedge clk) begin
      if (rst) begin
         lane          <= '0;
         host_ready    <= 1'b1;
         host_row_addr <= '0;
      end else if (host_accept) begin
         if (lane == '0) begin
            host_row_addr <= host_addr;
         end
         if (lane == LANE_W'(LANES - 1)) begin
            lane       <= '0;
            host_ready <= 1'b0;
         end else begin
            lane <= lane + LANE_W'(1);
         end
      end else if (state == HOST_WR) begin
         host_ready <= 1'b1;
      end
   end

   // Row data needs no reset: a discarded partial row is simply overwritten.
   always_ff @(posedge clk) begin
      if (host_accept) begin
         row_buf[lane] <= host_wdata;
      end
   end

endmodule

// File: tb/tb_weight_mem_arbiter.sv
// Directed bench for weight_mem_arbiter: core access table plus host-load,
// contention, backpressure and reset sequences.
module tb_weight_mem_arbiter;

   logic         clk;
   logic         rst;
   logic         core_req;
   logic         core_we;
   logic [7:0]   core_addr;
   logic [511:0] core_wdata;
   logic         core_gnt;
   logic         core_rvalid;
   logic [511:0] core_rdata;
   logic         host_valid;
   logic         host_ready;
   logic [7:0]   host_addr;
   logic [31:0]  host_wdata;
   logic         mem_rd;
   logic         mem_wr;
   logic [7:0]   mem_addr;
   logic [511:0] mem_wdata;
   logic [511:0] mem_rdata;

   int total;
   int bad;

   typedef struct {
      logic         we;
      logic [7:0]   addr;
      logic [511:0] wdata;
      logic [511:0] rdata;
      logic         exp_rd;
      logic         exp_wr;
      logic         exp_rvalid;
   } core_vec_t;

   core_vec_t vecs [5];

   weight_mem_arbiter dut (
      .clk         (clk),
      .rst         (rst),
      .core_req    (core_req),
      .core_we     (core_we),
      .core_addr   (core_addr),
      .core_wdata  (core_wdata),
      .core_gnt    (core_gnt),
      .core_rvalid (core_rvalid),
      .core_rdata  (core_rdata),
      .host_valid  (host_valid),
      .host_ready  (host_ready),
      .host_addr   (host_addr),
      .host_wdata  (host_wdata),
      .mem_rd      (mem_rd),
      .mem_wr      (mem_wr),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .mem_rdata   (mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   function automatic logic [511:0] make_row(input logic [31:0] base);
      logic [511:0] r;
      r = '0;
      for (int k = 0; k < 16; k++) begin
         r[32*k +: 32] = base + 32'(k);
      end
      return r;
   endfunction

   task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst        = 1'b1;
      core_req   = 1'b0;
      host_valid = 1'b0;
      step();
      rst = 1'b0;
   endtask

   // Leaves host_valid asserted after the last word.
   task automatic stream(input logic [7:0] a, input logic [31:0] base, input int n);
      for (int k = 0; k < n; k++) begin
         host_valid = 1'b1;
         host_addr  = a;
         host_wdata = base + 32'(k);
         chk("stream_ready", 512'(host_ready), 512'(1'b1));
         chk("stream_no_wr", 512'(mem_wr), 512'(1'b0));
         step();
      end
   endtask

   task automatic expect_host_write(input logic [7:0] a, input logic [31:0] base);
      chk("full_ready_low", 512'(host_ready), 512'(1'b0));
      chk("full_no_wr_yet", 512'(mem_wr), 512'(1'b0));
      step();
      chk("hwr_strobe", 512'(mem_wr), 512'(1'b1));
      chk("hwr_no_rd", 512'(mem_rd), 512'(1'b0));
      chk("hwr_addr", 512'(mem_addr), 512'(a));
      chk("hwr_data", mem_wdata, make_row(base));
      chk("hwr_no_core_gnt", 512'(core_gnt), 512'(1'b0));
      chk("hwr_ready_low", 512'(host_ready), 512'(1'b0));
      step();
      chk("hwr_ready_back", 512'(host_ready), 512'(1'b1));
      chk("hwr_single", 512'(mem_wr), 512'(1'b0));
   endtask

   initial begin
      int          prev_owner;
      int          owner;
      int          run;
      int          last_core;
      int          hw;
      int          cg;
      logic        prev_gnt;
      logic        acc;
      logic [31:0] hd;

      total      = 0;
      bad        = 0;
      rst        = 1'b1;
      core_req   = 1'b0;
      core_we    = 1'b0;
      core_addr  = '0;
      core_wdata = '0;
      host_valid = 1'b0;
      host_addr  = '0;
      host_wdata = '0;
      mem_rdata  = '0;

      vecs[0] = '{we: 1'b0, addr: 8'h05, wdata: '0, rdata: make_row(32'h5500),
                  exp_rd: 1'b1, exp_wr: 1'b0, exp_rvalid: 1'b1};
      vecs[1] = '{we: 1'b1, addr: 8'h11, wdata: make_row(32'hA000), rdata: '0,
                  exp_rd: 1'b0, exp_wr: 1'b1, exp_rvalid: 1'b0};
      vecs[2] = '{we: 1'b0, addr: 8'hFF, wdata: '0, rdata: make_row(32'h7700),
                  exp_rd: 1'b1, exp_wr: 1'b0, exp_rvalid: 1'b1};
      vecs[3] = '{we: 1'b1, addr: 8'h00, wdata: make_row(32'hB0B0), rdata: '0,
                  exp_rd: 1'b0, exp_wr: 1'b1, exp_rvalid: 1'b0};
      vecs[4] = '{we: 1'b0, addr: 8'h80, wdata: '0, rdata: make_row(32'hC3C3),
                  exp_rd: 1'b1, exp_wr: 1'b0, exp_rvalid: 1'b1};

      // Reset values
      step();
      step();
      rst = 1'b0;
      chk("rst_gnt", 512'(core_gnt), 512'(1'b0));
      chk("rst_rvalid", 512'(core_rvalid), 512'(1'b0));
      chk("rst_rd", 512'(mem_rd), 512'(1'b0));
      chk("rst_wr", 512'(mem_wr), 512'(1'b0));
      chk("rst_addr", 512'(mem_addr), 512'(8'h00));
      chk("rst_wdata", mem_wdata, '0);
      chk("rst_ready", 512'(host_ready), 512'(1'b1));

      // Core access table, idle memory
      for (int i = 0; i < 5; i++) begin
         core_req   = 1'b1;
         core_we    = vecs[i].we;
         core_addr  = vecs[i].addr;
         core_wdata = vecs[i].wdata;
         mem_rdata  = vecs[i].rdata;
         step();
         chk("tab_gnt", 512'(core_gnt), 512'(1'b1));
         chk("tab_rd", 512'(mem_rd), 512'(vecs[i].exp_rd));
         chk("tab_wr", 512'(mem_wr), 512'(vecs[i].exp_wr));
         chk("tab_addr", 512'(mem_addr), 512'(vecs[i].addr));
         if (vecs[i].we) chk("tab_wdata", mem_wdata, vecs[i].wdata);
         step();
         chk("tab_rvalid", 512'(core_rvalid), 512'(vecs[i].exp_rvalid));
         chk("tab_no_regrant", 512'(core_gnt), 512'(1'b0));
         chk("tab_strobe_off", 512'(mem_rd | mem_wr), 512'(1'b0));
         if (!vecs[i].we) chk("tab_rdata", core_rdata, vecs[i].rdata);
         core_req = 1'b0;
         step();
         chk("tab_idle_gnt", 512'(core_gnt), 512'(1'b0));
         chk("tab_idle_rvalid", 512'(core_rvalid), 512'(1'b0));
      end

      // Host row load
      do_reset();
      stream(8'h20, 32'h100, 16);
      host_valid = 1'b0;
      expect_host_write(8'h20, 32'h100);

      // Backpressure: next word held while full must wait for the write
      stream(8'h22, 32'h600, 16);
      host_wdata = 32'h200;
      host_addr  = 8'h60;
      chk("bp_ready_low", 512'(host_ready), 512'(1'b0));
      step();
      chk("bp_wr", 512'(mem_wr), 512'(1'b1));
      chk("bp_addr", 512'(mem_addr), 512'(8'h22));
      chk("bp_data", mem_wdata, make_row(32'h600));
      step();
      chk("bp_ready_back", 512'(host_ready), 512'(1'b1));
      stream(8'h60, 32'h200, 16);
      host_valid = 1'b0;
      expect_host_write(8'h60, 32'h200);

      // Reset during a read grant cycle
      core_req  = 1'b1;
      core_we   = 1'b0;
      core_addr = 8'h09;
      step();
      chk("rg_rd", 512'(mem_rd), 512'(1'b1));
      rst      = 1'b1;
      core_req = 1'b0;
      step();
      chk("rg_rd_off", 512'(mem_rd), 512'(1'b0));
      chk("rg_gnt_off", 512'(core_gnt), 512'(1'b0));
      chk("rg_rvalid_off", 512'(core_rvalid), 512'(1'b0));
      chk("rg_addr_zero", 512'(mem_addr), 512'(8'h00));
      rst = 1'b0;
      step();
      chk("rg_no_rvalid", 512'(core_rvalid), 512'(1'b0));

      // Reset mid-row discards the partial row
      stream(8'h70, 32'hAAA, 7);
      rst        = 1'b1;
      host_valid = 1'b0;
      step();
      rst = 1'b0;
      chk("mr_no_wr", 512'(mem_wr), 512'(1'b0));
      chk("mr_ready", 512'(host_ready), 512'(1'b1));
      stream(8'h30, 32'h300, 16);
      host_valid = 1'b0;
      expect_host_write(8'h30, 32'h300);

      // Simultaneous contention, first conflict after reset
      do_reset();
      stream(8'h21, 32'h400, 16);
      host_valid = 1'b0;
      core_req   = 1'b1;
      core_we    = 1'b1;
      core_addr  = 8'h40;
      core_wdata = make_row(32'h900);
      chk("sc_full", 512'(host_ready), 512'(1'b0));
      step();
      chk("sc_core_gnt", 512'(core_gnt), 512'(1'b1));
      chk("sc_core_wr", 512'(mem_wr), 512'(1'b1));
      chk("sc_core_addr", 512'(mem_addr), 512'(8'h40));
      chk("sc_core_data", mem_wdata, make_row(32'h900));
      step();
      core_req = 1'b0;
      chk("sc_host_no_gnt", 512'(core_gnt), 512'(1'b0));
      chk("sc_host_wr", 512'(mem_wr), 512'(1'b1));
      chk("sc_host_addr", 512'(mem_addr), 512'(8'h21));
      chk("sc_host_data", mem_wdata, make_row(32'h400));
      step();
      chk("sc_idle_wr", 512'(mem_wr), 512'(1'b0));
      chk("sc_ready_back", 512'(host_ready), 512'(1'b1));

      // Continuous contention: core always requesting, host always streaming
      do_reset();
      prev_owner = 0;
      run        = 0;
      last_core  = -1;
      hw         = 0;
      cg         = 0;
      prev_gnt   = 1'b0;
      hd         = 32'h1000;
      core_req   = 1'b1;
      core_we    = 1'b0;
      core_addr  = 8'h07;
      host_valid = 1'b1;
      host_addr  = 8'h50;
      for (int c = 0; c < 100; c++) begin
         host_wdata = hd;
         acc = host_ready;
         step();
         if (acc) hd = hd + 32'd1;
         chk("cc_two_strobes", 512'(mem_rd & mem_wr), 512'(1'b0));
         chk("cc_rvalid", 512'(core_rvalid), 512'(prev_gnt));
         owner = core_gnt ? 1 : (mem_wr ? 2 : 0);
         chk("cc_alternate", 512'(owner != 0 && owner == prev_owner), 512'(1'b0));
         if (core_gnt) begin
            if (last_core >= 0)
               chk("cc_core_gap", 512'((c - last_core) >= 2 && (c - last_core) <= 3), 512'(1'b1));
            last_core = c;
            cg++;
         end
         if (mem_wr) begin
            chk("cc_host_row", mem_wdata, make_row(32'h1000 + 32'(16 * hw)));
            chk("cc_host_addr", 512'(mem_addr), 512'(8'h50));
            hw++;
         end
         if (!host_ready) begin
            run++;
         end else if (run > 0) begin
            chk("cc_host_wait", 512'(run >= 2 && run <= 3), 512'(1'b1));
            run = 0;
         end
         prev_gnt   = core_gnt;
         prev_owner = owner;
      end
      chk("cc_host_writes", 512'(hw >= 4), 512'(1'b1));
      chk("cc_core_grants", 512'(cg >= 30), 512'(1'b1));
      core_req   = 1'b0;
      host_valid = 1'b0;
      step();
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
